// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - size codes, FSM encodings and byte-enable constants for mem_access_unit
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] BE_B0      = 4'b0001;
  localparam logic [3:0] BE_B1      = 4'b0010;
  localparam logic [3:0] BE_B2      = 4'b0100;
  localparam logic [3:0] BE_B3      = 4'b1000;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Reserved size falls through to word when alignment checking is off.
  function automatic logic [3:0] be_encode(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: begin
        case (a)
          2'b00:   be = BE_B0;
          2'b01:   be = BE_B1;
          2'b10:   be = BE_B2;
          default: be = BE_B3;
        endcase
      end
      SIZE_HALF: be = a[1] ? BE_HALF_HI : BE_HALF_LO;
      default:   be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SIZE_HALF) && a[0]) ||
           ((size == SIZE_WORD) && (a != 2'b00)) ||
           (size == SIZE_RSVD);
  endfunction

endpackage

// File: rtl/mau_load_extract.sv
// rtl/mau_load_extract.sv - load lane select with zero/sign extension
module mau_load_extract
  import mau_pkg::*;
(
  input  logic [31:0] mem_RD,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = mem_RD >> {addr, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (size)
      SIZE_BYTE: rdata = {{24{sgn & byte_v[7]}}, byte_v};
      SIZE_HALF: rdata = {{16{sgn & half_v[15]}}, half_v};
      default:   rdata = mem_RD;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store initiator for the byte-enabled data memory
// Optional alignment/reserved-size checking: define MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_A,
  output logic [3:0]        mem_BE,
  output logic [31:0]       mem_WD,
  output logic              mem_We,
  input  logic [31:0]       mem_RD
);

  logic [1:0]  state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_addr;
  logic        lat_signed;
  logic        lat_we;
  logic        lat_err;
  logic        acc_err;
  logic [31:0] ext_rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[ADDR_W-1:MEM_AW+2];
  assign req_ready = (state == IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign acc_err = misaligned(req_size, req_addr[1:0]);
`else
  assign acc_err = 1'b0;
`endif

  mau_load_extract u_extract (
    .mem_RD (mem_RD),
    .addr   (lat_addr),
    .size   (lat_size),
    .sgn    (lat_signed),
    .rdata  (ext_rdata)
  );

  // Memory-side outputs are loaded at acceptance so they are stable for the whole ACCESS cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      mem_A      <= '0;
      mem_BE     <= '0;
      mem_WD     <= '0;
      mem_We     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_size   <= SIZE_BYTE;
      lat_addr   <= 2'b00;
      lat_signed <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            state      <= ACCESS;
            lat_size   <= req_size;
            lat_addr   <= req_addr[1:0];
            lat_signed <= req_signed;
            lat_we     <= req_we;
            lat_err    <= acc_err;
            mem_A      <= req_addr[MEM_AW+1:2];
            mem_WD     <= req_wdata;
            mem_BE     <= acc_err ? 4'b0000 : be_encode(req_size, req_addr[1:0]);
            mem_We     <= req_we & ~acc_err;
          end
        end
        ACCESS: begin
          state      <= RESP;
          mem_We     <= 1'b0;
          mem_BE     <= 4'b0000;
          resp_valid <= 1'b1;
          resp_err   <= lat_err;
          resp_rdata <= (lat_we || lat_err) ? 32'h0 : ext_rdata;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mem_We     <= 1'b0;
          mem_BE     <= 4'b0000;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a byte-enabled memory model
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [10:0] mem_A;
  logic [3:0]  mem_BE;
  logic [31:0] mem_WD;
  logic        mem_We;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:2047];
  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  mem_access_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_BE     (mem_BE),
    .mem_WD     (mem_WD),
    .mem_We     (mem_We),
    .mem_RD     (mem_RD)
  );

  // Memory aligns right-justified write data into the enabled lanes.
  assign mem_RD = mem[mem_A];
  always @(posedge Clk) begin
    if (mem_We) begin
      case (mem_BE)
        4'b0001: mem[mem_A][7:0]   <= mem_WD[7:0];
        4'b0010: mem[mem_A][15:8]  <= mem_WD[7:0];
        4'b0100: mem[mem_A][23:16] <= mem_WD[7:0];
        4'b1000: mem[mem_A][31:24] <= mem_WD[7:0];
        4'b0011: mem[mem_A][15:0]  <= mem_WD[15:0];
        4'b1100: mem[mem_A][31:16] <= mem_WD[15:0];
        4'b1111: mem[mem_A]        <= mem_WD;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [10:0] e_a, input logic [3:0] e_be, input logic e_we,
                        input logic [31:0] e_rd, input logic e_err);
    @(negedge Clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    chk({tag, " busy"}, 32'(req_ready), 32'd0);
    chk({tag, " mem_A"}, 32'(mem_A), 32'(e_a));
    chk({tag, " mem_BE"}, 32'(mem_BE), 32'(e_be));
    chk({tag, " mem_We"}, 32'(mem_We), 32'(e_we));
    chk({tag, " mem_WD"}, mem_WD, wdata);
    chk({tag, " early resp"}, 32'(resp_valid), 32'd0);
    @(negedge Clk);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " rdata"}, resp_rdata, e_rd);
    chk({tag, " err"}, 32'(resp_err), 32'(e_err));
    chk({tag, " We drop"}, 32'(mem_We), 32'd0);
    chk({tag, " BE drop"}, 32'(mem_BE), 32'd0);
    @(negedge Clk);
    chk({tag, " pulse end"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst mem_We", 32'(mem_We), 32'd0);
    chk("rst mem_BE", 32'(mem_BE), 32'd0);
    chk("rst mem_A", 32'(mem_A), 32'd0);
    chk("rst mem_WD", mem_WD, 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    access("st byte", 1'b1, 2'b00, 1'b0, 32'h0006, 32'h123456AB, 11'h001, 4'b0100, 1'b1, 32'h0, 1'b0);
    access("ld sbyte", 1'b0, 2'b00, 1'b1, 32'h0006, 32'h0, 11'h001, 4'b0100, 1'b0, 32'hFFFFFFAB, 1'b0);
    access("ld ubyte", 1'b0, 2'b00, 1'b0, 32'h0006, 32'h0, 11'h001, 4'b0100, 1'b0, 32'h000000AB, 1'b0);
    access("ld byte3", 1'b0, 2'b00, 1'b1, 32'h0007, 32'h0, 11'h001, 4'b1000, 1'b0, 32'h0, 1'b0);
    access("st half", 1'b1, 2'b01, 1'b0, 32'h0002, 32'h0000BEEF, 11'h000, 4'b1100, 1'b1, 32'h0, 1'b0);
    access("ld shalf", 1'b0, 2'b01, 1'b1, 32'h0002, 32'h0, 11'h000, 4'b1100, 1'b0, 32'hFFFFBEEF, 1'b0);
    access("ld uhalf", 1'b0, 2'b01, 1'b0, 32'h0002, 32'h0, 11'h000, 4'b1100, 1'b0, 32'h0000BEEF, 1'b0);
    access("ld half0", 1'b0, 2'b01, 1'b1, 32'h0000, 32'h0, 11'h000, 4'b0011, 1'b0, 32'h0, 1'b0);
    access("ld sbyte3", 1'b0, 2'b00, 1'b1, 32'h0003, 32'h0, 11'h000, 4'b1000, 1'b0, 32'hFFFFFFBE, 1'b0);
    access("st word", 1'b1, 2'b10, 1'b0, 32'h1FFC, 32'hDEADBEEF, 11'h7FF, 4'b1111, 1'b1, 32'h0, 1'b0);
    access("ld word", 1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 11'h7FF, 4'b1111, 1'b0, 32'hDEADBEEF, 1'b0);
    access("ld alias", 1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 11'h7FF, 4'b1111, 1'b0, 32'hDEADBEEF, 1'b0);

    // Back-to-back loads with req_valid held high.
    @(negedge Clk);
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b1; req_addr = 32'h0006; req_valid = 1'b1;
    @(negedge Clk);
    chk("b2b ready access", 32'(req_ready), 32'd0);
    chk("b2b resp0 early", 32'(resp_valid), 32'd0);
    req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h1FFC;
    @(negedge Clk);
    chk("b2b ready resp", 32'(req_ready), 32'd0);
    chk("b2b resp0", 32'(resp_valid), 32'd1);
    chk("b2b rdata0", resp_rdata, 32'hFFFFFFAB);
    @(negedge Clk);
    chk("b2b ready idle", 32'(req_ready), 32'd1);
    chk("b2b gap", 32'(resp_valid), 32'd0);
    @(negedge Clk);
    req_valid = 1'b0;
    chk("b2b second accepted", 32'(req_ready), 32'd0);
    chk("b2b second A", 32'(mem_A), 32'h7FF);
    chk("b2b resp1 early", 32'(resp_valid), 32'd0);
    @(negedge Clk);
    chk("b2b resp1", 32'(resp_valid), 32'd1);
    chk("b2b rdata1", resp_rdata, 32'hDEADBEEF);
    @(negedge Clk);

    // Reset in the middle of a store's ACCESS cycle.
    @(negedge Clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0010; req_wdata = 32'h00000055; req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    chk("rst-mid We before", 32'(mem_We), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("rst-mid We async", 32'(mem_We), 32'd0);
    chk("rst-mid BE async", 32'(mem_BE), 32'd0);
    @(negedge Clk);
    chk("rst-mid no resp", 32'(resp_valid), 32'd0);
    Reset = 1'b0;
    chk("rst-mid ready", 32'(req_ready), 32'd1);
    @(negedge Clk);
    chk("rst-mid no resp later", 32'(resp_valid), 32'd0);
    access("ld aborted", 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0, 11'h004, 4'b1111, 1'b0, 32'h0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    access("st misaligned", 1'b1, 2'b10, 1'b0, 32'h0005, 32'hCAFEF00D, 11'h001, 4'b0000, 1'b0, 32'h0, 1'b1);
    access("ld after misal", 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0, 11'h001, 4'b1111, 1'b0, 32'h00AB0000, 1'b0);
    access("ld rsvd", 1'b0, 2'b11, 1'b0, 32'h0004, 32'h0, 11'h001, 4'b0000, 1'b0, 32'h0, 1'b1);
`else
    access("st misaligned", 1'b1, 2'b10, 1'b0, 32'h0005, 32'hCAFEF00D, 11'h001, 4'b1111, 1'b1, 32'h0, 1'b0);
    access("ld after misal", 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0, 11'h001, 4'b1111, 1'b0, 32'hCAFEF00D, 1'b0);
    access("ld rsvd", 1'b0, 2'b11, 1'b0, 32'h0004, 32'h0, 11'h001, 4'b1111, 1'b0, 32'hCAFEF00D, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
